sha_digest_reader: RTL

Reads the final 256-bit digest out of the eight hash-state registers (H0..H7) after the second SHA-256 pass of a nonce. It optionally compares the digest against a 256-bit difficulty target, then streams the eight words to the host-side interface over a valid/ready handshake. It sits downstream of the H-register bank and is the consumer end of the `Block`/`H*_out` state-update path.

---
 rtl/sha_digest_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sha_digest_reader.sv
// Streams the final SHA-256 digest (H0..H7) to the host over valid/ready.
// Define SHA_DIGEST_CMP_EN to compile in the digest <= target comparison stage.
module sha_digest_reader #(
    parameter int WORDS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   Block,
    input  logic         h_valid,
    input  logic [255:0] h_in,
    input  logic [255:0] target,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         found,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    localparam int DATA_W = 32;
    localparam int DIG_W  = 256;
    localparam int IDX_W  = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

`ifdef SHA_DIGEST_CMP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    // Without the comparator a single settle cycle keeps the first word at T+2.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIG_W-1:0]   dig_q;
    logic               overrun_q;
    logic               cap_req;
    logic               cap_en;
    logic [DATA_W-1:0]  dig_w;

    // H0 sits in the most significant word, so word i counts down from the top.
    function automatic logic [DATA_W-1:0] word_at(input logic [DIG_W-1:0] v,
                                                  input logic [IDX_W-1:0] i);
        word_at = v[DIG_W-1 - DATA_W*int'(i) -: DATA_W];
    endfunction

    assign cap_req = h_valid && (Block == 2'd3);
    assign dig_w   = word_at(dig_q, idx_q);

`ifdef SHA_DIGEST_CMP_EN
    logic [DIG_W-1:0]  tgt_q;
    logic              found_q, found_d;
    logic [DATA_W-1:0] tgt_w;

    assign tgt_w = word_at(tgt_q, idx_q);
    assign found = found_q;
`else
    logic unused_target;

    assign unused_target = ^target;
    assign found         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_en    = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
`ifdef SHA_DIGEST_CMP_EN
        found_d   = found_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cap_req) begin
                    cap_en = 1'b1;
                    idx_d  = '0;
`ifdef SHA_DIGEST_CMP_EN
                    found_d = 1'b0;
                    state_d = S_CMP;
`else
                    state_d = S_LOAD;
`endif
                end
            end
`ifdef SHA_DIGEST_CMP_EN
            S_CMP: begin
                // Most significant word first: the first differing word decides.
                if (dig_w != tgt_w) begin
                    found_d = (dig_w < tgt_w);
                    idx_d   = '0;
                    state_d = S_SEND;
                end else if (idx_q == LAST_IDX) begin
                    found_d = 1'b1;
                    idx_d   = '0;
                    state_d = S_SEND;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`else
            S_LOAD: begin
                state_d = S_SEND;
            end
`endif
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = dig_w;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            dig_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            if (cap_en) begin
                dig_q <= h_in;
            end
            // A request that arrives mid-transfer is dropped but remembered.
            if (cap_req && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef SHA_DIGEST_CMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q   <= '0;
            found_q <= 1'b0;
        end else begin
            found_q <= found_d;
            if (cap_en) begin
                tgt_q <= target;
            end
        end
    end
`endif

    assign overrun = overrun_q;

endmodule
